// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WAIT_MAX     : largest supported WAIT_STATES value
//   WORD_BYTES   : bytes per 32-bit word (width of the byte mask)
//   dmem_req_t   : request fields captured at acceptance
//   addr_bad()   : misalignment / out-of-range check on a byte address
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned WAIT_MAX   = 7;
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [WORD_BYTES-1:0] be;
  } dmem_req_t;

  // A byte address is rejected when it is not word aligned or when any bit
  // above the array's word-index field is set (no aliasing into the array).
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned aw);
    logic bad;
    bad = (addr[1:0] != 2'b00);
    for (int unsigned i = 2; i < 32; i++) begin
      if ((i >= aw + 2) && addr[i]) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
// Word-addressed 32-bit storage array: asynchronous read, synchronous write
// with a per-byte write mask. Contents have no reset.
//   clk     : write clock (rising edge)
//   we_i    : write enable
//   addr_i  : word index
//   wdata_i : write data
//   be_i    : byte mask, bit n enables byte n (little-endian)
//   rdata_o : combinational read of word addr_i
// -----------------------------------------------------------------------------
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [WORD_BYTES-1:0] be_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-side memory target for the core's load/store port. Accepts one word
// request at a time (req/ack), inserts WAIT_STATES wait cycles, then reads or
// writes the internal array. Misaligned or out-of-range addresses are answered
// immediately with an error response and no array access.
//
// Optional feature macro: DMEM_BYTE_STROBE_EN
//   defined     : be_i port exists; stores write only enabled bytes
//   not defined : be_i absent; stores write the full word
//
// Parameters
//   ADDR_WIDTH  : word-address bits (2^ADDR_WIDTH words of 32 bits)
//   WAIT_STATES : wait cycles between acceptance and access, 0..7
// Ports
//   clk       : clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   req_i     : request valid, sampled only in IDLE
//   we_i      : 1 = store, 0 = load
//   addr_i    : byte address
//   wdata_i   : store data
//   be_i      : byte enables (DMEM_BYTE_STROBE_EN only)
//   ack_o     : one-cycle completion pulse
//   err_o     : error flag, valid with ack_o
//   rdata_o   : load data, valid while ack_o is high
//   busy_o    : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  if (WAIT_STATES > WAIT_MAX) begin : g_cfg_check
    $error("dmem_responder: WAIT_STATES out of range 0..7");
  end

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0
                                                        : 3'(WAIT_STATES - 1);

  dmem_state_t state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  dmem_req_t   req_q, req_d;
  logic        flag_q, flag_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;

  dmem_req_t   in_req;
  logic        in_bad;
  dmem_req_t   cur;
  logic        access_en;
  logic [31:0] mem_rdata;

  always_comb begin
    in_req.we    = we_i;
    in_req.addr  = addr_i;
    in_req.wdata = wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
    in_req.be    = be_i;
`else
    in_req.be    = '1;
`endif
  end

  assign in_bad = addr_bad(addr_i, ADDR_WIDTH);

  // With zero wait states the access happens on the acceptance edge, so the
  // array is driven from the live inputs while in IDLE and from the latched
  // request otherwise.
  dmem_sram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk     (clk),
    .we_i    (access_en && cur.we),
    .addr_i  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata_i (cur.wdata),
    .be_i    (cur.be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      req_q      <= '0;
      flag_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      flag_q     <= flag_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    flag_d     = flag_q;
    rdata_d    = rdata_q;
    access_en  = 1'b0;
    cur        = req_q;

    unique case (state_q)
      IDLE: begin
        cur = in_req;
        if (req_i) begin
          req_d  = in_req;
          flag_d = in_bad;
          if (in_bad) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (WAIT_STATES == 0) begin
            access_en = 1'b1;
            state_d   = RESP;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q != 3'd0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          access_en = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (access_en && !cur.we) begin
      rdata_d = mem_rdata;
    end

    // Registering the RESP state places the ack pulse in the cycle after RESP,
    // which is also the IDLE cycle where the next request may be sampled.
    ack_d  = (state_q == RESP);
    err_d  = (state_q == RESP) && flag_q;
    busy_d = (state_d != IDLE);
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[31:ADDR_WIDTH+2], req_q.addr[1:0]};

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  int          sel = 1;

  logic req0, req1, req3;
  logic ack0, ack1, ack3, err0, err1, err3, busy0, busy1, busy3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic ack_s, err_s, busy_s;
  logic [31:0] rdata_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign req0 = req && (sel == 0);
  assign req1 = req && (sel == 1);
  assign req3 = req && (sel == 3);

  always_comb begin
    ack_s = ack0; err_s = err0; busy_s = busy0; rdata_s = rdata0;
    if (sel == 1) begin
      ack_s = ack1; err_s = err1; busy_s = busy1; rdata_s = rdata1;
    end else if (sel == 3) begin
      ack_s = ack3; err_s = err3; busy_s = busy3; rdata_s = rdata3;
    end
  end

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n_i(rst_n), .req_i(req0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be),
`endif
    .ack_o(ack0), .err_o(err0), .rdata_o(rdata0), .busy_o(busy0));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset_n_i(rst_n), .req_i(req1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be),
`endif
    .ack_o(ack1), .err_o(err1), .rdata_o(rdata1), .busy_o(busy1));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n_i(rst_n), .req_i(req3), .we_i(we), .addr_i(addr),
    .wdata_i(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be),
`endif
    .ack_o(ack3), .err_o(err3), .rdata_o(rdata3), .busy_o(busy3));

  // Issues one request on the selected DUT starting just after a clock edge.
  // lat = edges from acceptance to the first ack sample (0 = never seen).
  // ack2 = ack one cycle later; busy_acc = busy just after acceptance.
  // scramble changes the live inputs right after acceptance.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic scramble,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic ack2, output logic busy_acc);
    we = w; addr = a; wdata = d; be = b; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    busy_acc = busy_s;
    if (scramble) begin
      addr = a + 32'd4; wdata = ~d; we = ~w;
    end
    lat = 0; rd = '0; er = 1'b0; ack2 = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (ack_s === 1'b1) begin
        lat = c; rd = rdata_s; er = err_s;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      ack2 = ack_s;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ((ack0 | ack1 | ack3) !== 1'b0) begin
      failures++; $display("FAIL reset_ack: got %b%b%b expected 000", ack0, ack1, ack3);
    end
    checks++;
    if ((err0 | err1 | err3) !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b%b%b expected 000", err0, err1, err3);
    end
    checks++;
    if ((busy0 | busy1 | busy3) !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b%b%b expected 000", busy0, busy1, busy3);
    end
    checks++;
    if ((rdata0 | rdata1 | rdata3) !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 0", rdata0 | rdata1 | rdata3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ws1_store_load();
    int lat; logic [31:0] rd; logic er, a2, bz;
    sel = 1;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ws1_store_lat: got %0d expected 2", lat); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL ws1_store_err: got %b expected 0", er); end
    checks++;
    if (bz !== 1'b1) begin failures++; $display("FAIL ws1_busy_accept: got %b expected 1", bz); end
    checks++;
    if (a2 !== 1'b0) begin failures++; $display("FAIL ws1_ack_one_cycle: got %b expected 0", a2); end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ws1_load_lat: got %0d expected 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ws1_load_data: got %h expected deadbeef", rd); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL ws1_load_err: got %b expected 0", er); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, a2, bz;
    sel = 1;
    do_req(1'b0, 32'h6, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL err_misalign_lat: got %0d expected 1", lat); end
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL err_misalign_err: got %b expected 1", er); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL err_misalign_rdata: got %h expected 0", rd); end
    do_req(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL err_range_lat: got %0d expected 1", lat); end
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL err_range_err: got %b expected 1", er); end
    // 0x1010 would alias word 4 (0x10) if the range check were missing.
    do_req(1'b1, 32'h1010, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL err_alias_store_err: got %b expected 1", er); end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_no_write: got %h expected deadbeef", rd); end
    do_req(1'b1, 32'hFFC, 32'hA5A50FF0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL top_word_store_err: got %b expected 0", er); end
    do_req(1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'hA5A50FF0) begin failures++; $display("FAIL top_word_load: got %h expected a5a50ff0", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, a2, bz;
    logic exp_ack, exp_busy;
    sel = 0;
    we = 1'b1; addr = 32'h40; wdata = 32'h01020304; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_ack  = (i % 2 == 1);
      exp_busy = (i % 2 == 0);
      checks++;
      if (ack_s !== exp_ack) begin
        failures++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, ack_s, exp_ack);
      end
      checks++;
      if (busy_s !== exp_busy) begin
        failures++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, busy_s, exp_busy);
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ack_s, busy_s} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle: got ack/busy %b%b expected 00", ack_s, busy_s);
    end
    do_req(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL ws0_load_lat: got %0d expected 1", lat); end
    checks++;
    if (rd !== 32'h01020304) begin failures++; $display("FAIL ws0_load_data: got %h expected 01020304", rd); end
  endtask

  task automatic test_reset_in_wait();
    int lat; int acks; logic [31:0] rd; logic er, a2, bz;
    sel = 3;
    do_req(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ws3_store_lat: got %0d expected 4", lat); end
    do_req(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL ws3_load_data: got %h expected cafef00d", rd); end
    we = 1'b1; addr = 32'h8; wdata = 32'h5; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack_s, err_s, busy_s} !== 3'b000) begin
      failures++; $display("FAIL rst_wait_ctrl: got ack/err/busy %b%b%b expected 000", ack_s, err_s, busy_s);
    end
    checks++;
    if (rdata_s !== 32'h0) begin failures++; $display("FAIL rst_wait_rdata: got %h expected 0", rdata_s); end
    @(posedge clk); #1;
    checks++;
    if (busy_s !== 1'b0) begin failures++; $display("FAIL rst_hold_busy: got %b expected 0", busy_s); end
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack_s === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL dropped_store_ack: got %0d acks expected 0", acks); end
    do_req(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL post_rst_load_lat: got %0d expected 4", lat); end
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL post_rst_load_data: got %h expected cafef00d", rd); end
  endtask

  task automatic test_latched();
    int lat; logic [31:0] rd; logic er, a2, bz;
    sel = 3;
    do_req(1'b1, 32'h34, 32'h0BADF00D, 4'hF, 1'b0, lat, rd, er, a2, bz);
    do_req(1'b1, 32'h30, 32'h12345678, 4'hF, 1'b1, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL latched_store_lat: got %0d expected 4", lat); end
    do_req(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'h12345678) begin failures++; $display("FAIL latched_data: got %h expected 12345678", rd); end
    do_req(1'b0, 32'h34, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL latched_addr: got %h expected 0badf00d", rd); end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_strobe();
    int lat; logic [31:0] rd; logic er, a2, bz;
    sel = 1;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, lat, rd, er, a2, bz);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd, er, a2, bz);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge: got %h expected 11bb33dd", rd); end
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL strobe_noop_lat: got %0d expected 2", lat); end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_noop_data: got %h expected 11bb33dd", rd); end
  endtask
`else
  task automatic test_full_word_store();
    int lat; logic [31:0] rd; logic er, a2, bz;
    sel = 1;
    do_req(1'b1, 32'h20, 32'h11223344, 4'h0, 1'b0, lat, rd, er, a2, bz);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd, er, a2, bz);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er, a2, bz);
    checks++;
    if (rd !== 32'hAABBCCDD) begin failures++; $display("FAIL full_word_store: got %h expected aabbccdd", rd); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ws1_store_load();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    test_latched();
`ifdef DMEM_BYTE_STROBE_EN
    test_strobe();
`else
    test_full_word_store();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
